// File: rtl/muldiv_hilo_pkg.sv
// rtl/muldiv_hilo_pkg.sv - shared op codes and FSM state type for the HI/LO multiply/divide unit
package muldiv_hilo_pkg;

    localparam logic [3:0] OP_MULT  = 4'h0;
    localparam logic [3:0] OP_MULTU = 4'h1;
    localparam logic [3:0] OP_DIV   = 4'h2;
    localparam logic [3:0] OP_DIVU  = 4'h3;
    localparam logic [3:0] OP_MTHI  = 4'h4;
    localparam logic [3:0] OP_MTLO  = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_e;

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// rtl/muldiv_hilo_div_iter.sv - radix-2 restoring divider datapath on magnitudes with output sign fix
module muldiv_hilo_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH:0]   shifted, diff;
    logic             a_neg, b_neg;

    always_comb begin
        a_neg   = signed_i & dividend_i[WIDTH-1];
        b_neg   = signed_i & divisor_i[WIDTH-1];
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (load_i) begin
            quo_d  = a_neg ? -dividend_i : dividend_i;
            rem_d  = '0;
            dvs_d  = b_neg ? -divisor_i : divisor_i;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
        end else if (step_i) begin
            // Quotient bits shift in where dividend bits shift out.
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        quo_q  <= quo_d;
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign quo_o = qneg_q ? -quo_q : quo_q;
    assign rem_o = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - HI/LO multiply/divide unit with pipelined multiplier and iterative divider
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] pipe_q [MUL_LAT];
    logic [2*WIDTH-1:0] mul_a, mul_b;
    logic               mul_sgn, accept, div_step;
    logic [WIDTH-1:0]   quo, rem;

    assign accept   = start & (state_q == ST_IDLE) & ~cancel;
    assign div_step = (state_q == ST_DIV) && (cnt_q != DIV_LAST);
    assign mul_sgn  = op_is_signed(op);
    assign mul_a    = {{WIDTH{mul_sgn & src1[WIDTH-1]}}, src1};
    assign mul_b    = {{WIDTH{mul_sgn & src2[WIDTH-1]}}, src2};

    // Free-running product pipeline; the FSM picks the tap that holds the E0 product.
    always_ff @(posedge clk) begin
        pipe_q[0] <= mul_a * mul_b;
        for (int k = 1; k < MUL_LAT; k++) begin
            pipe_q[k] <= pipe_q[k-1];
        end
    end

    muldiv_hilo_div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk        (clk),
        .load_i     (accept),
        .step_i     (div_step),
        .signed_i   (mul_sgn),
        .dividend_i (src1),
        .divisor_i  (src2),
        .quo_o      (quo),
        .rem_o      (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            if (cancel) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (start) begin
                            case (op)
                                OP_MTHI: begin
                                    hi_q   <= src1;
                                    done_q <= 1'b1;
                                end
                                OP_MTLO: begin
                                    lo_q   <= src1;
                                    done_q <= 1'b1;
                                end
                                OP_MULT, OP_MULTU: state_q <= ST_MUL;
                                OP_DIV, OP_DIVU: begin
                                    if (src2 == '0) begin
                                        done_q <= 1'b1;
                                        dz_q   <= 1'b1;
                                    end else begin
                                        state_q <= ST_DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (cnt_q == MUL_LAST) begin
                            {hi_q, lo_q} <= pipe_q[MUL_LAT-1];
                            done_q       <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_DIV: begin
                        if (cnt_q == DIV_LAST) begin
                            hi_q    <= rem;
                            lo_q    <= quo;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking bench for muldiv_hilo at WIDTH=32/MUL_LAT=2 and WIDTH=16/MUL_LAT=1
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, cancel = 1'b0, sel = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] src1 = '0, src2 = '0;

    logic        busy_a, done_a, dz_a, busy_b, done_b, dz_b;
    logic [31:0] hi_a, lo_a;
    logic [15:0] hi_b, lo_b;
    logic        o_busy, o_done, o_dz;
    logic [31:0] o_hi, o_lo;

    int          checks = 0, errors = 0;
    int          w = 32, lat = 2, s = 0;
    logic [31:0] m_hi [2], m_lo [2];
    logic        m_dz;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(32), .MUL_LAT(2)) u_w32 (
        .clk(clk), .rst(rst), .start(start & ~sel), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .busy(busy_a), .done(done_a), .div_zero(dz_a), .hi_o(hi_a), .lo_o(lo_a)
    );

    muldiv_hilo #(.WIDTH(16), .MUL_LAT(1)) u_w16 (
        .clk(clk), .rst(rst), .start(start & sel), .op(op), .src1(src1[15:0]), .src2(src2[15:0]),
        .cancel(cancel), .busy(busy_b), .done(done_b), .div_zero(dz_b), .hi_o(hi_b), .lo_o(lo_b)
    );

    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_dz   = sel ? dz_b : dz_a;
    assign o_hi   = sel ? {16'h0, hi_b} : hi_a;
    assign o_lo   = sel ? {16'h0, lo_b} : lo_a;

    function automatic logic [31:0] m32();
        return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic longint sx(input logic [31:0] v);
        logic [15:0] h;
        h = v[15:0];
        return (w == 32) ? longint'($signed(v)) : longint'($signed(h));
    endfunction

    // Architectural model: HI/LO as plain integer product / quotient / remainder.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mk, p, ua, ub;
        longint      sa, sb, q, r;
        mk   = {32'h0, m32()};
        ua   = {32'h0, a} & mk;
        ub   = {32'h0, b} & mk;
        sa   = sx(a);
        sb   = sx(b);
        m_dz = 1'b0;
        case (o)
            OP_MULT: begin
                p = 64'(sa * sb);
                m_hi[s] = 32'((p >> w) & mk);
                m_lo[s] = 32'(p & mk);
            end
            OP_MULTU: begin
                p = ua * ub;
                m_hi[s] = 32'((p >> w) & mk);
                m_lo[s] = 32'(p & mk);
            end
            OP_DIV: begin
                if (sb == 0) m_dz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo[s] = 32'(64'(q) & mk);
                    m_hi[s] = 32'(64'(r) & mk);
                end
            end
            OP_DIVU: begin
                if (ub == 0) m_dz = 1'b1;
                else begin
                    m_lo[s] = 32'(ua / ub);
                    m_hi[s] = 32'(ua % ub);
                end
            end
            OP_MTHI: m_hi[s] = 32'(ua);
            OP_MTLO: m_lo[s] = 32'(ua);
            default: ;
        endcase
    endfunction

    function automatic int exp_cyc(input logic [3:0] o, input logic [31:0] b);
        if (o == OP_MULT || o == OP_MULTU) return lat + 1;
        if (o == OP_DIV || o == OP_DIVU) return ((b & m32()) == 0) ? 1 : w + 2;
        return 1;
    endfunction

    function automatic int exp_busy(input logic [3:0] o, input logic [31:0] b);
        if (o == OP_MULT || o == OP_MULTU) return lat;
        if (o == OP_DIV || o == OP_DIVU) return ((b & m32()) == 0) ? 0 : w + 1;
        return 0;
    endfunction

    task automatic set_cfg(input int c);
        sel = c[0];
        s   = c;
        w   = (c == 0) ? 32 : 16;
        lat = (c == 0) ? 2 : 1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        op    = 4'($urandom_range(0, 5));
    endtask

    task automatic observe(output int cyc, output int bn, output logic dz, output logic [31:0] hi,
                           output logic [31:0] lo, output logic extra);
        cyc = 0; bn = 0; dz = 1'b0; hi = '0; lo = '0; extra = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (o_busy) bn++;
            if (o_dz && !o_done) extra = 1'b1;
            if (o_done) begin
                cyc = i; dz = o_dz; hi = o_hi; lo = o_lo;
                break;
            end
        end
        if (cyc != 0) begin
            @(negedge clk);
            if (o_done || o_dz) extra = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy_a, done_a, dz_a, hi_a, lo_a} !== 67'h0 || {busy_b, done_b, dz_b, hi_b, lo_b} !== 35'h0) begin
            errors++;
            $display("FAIL reset_state: w32 b/d/z=%b%b%b hi=%h lo=%h w16 b/d/z=%b%b%b hi=%h lo=%h expected all zero",
                     busy_a, done_a, dz_a, hi_a, lo_a, busy_b, done_b, dz_b, hi_b, lo_b);
        end
        m_hi = '{32'h0, 32'h0};
        m_lo = '{32'h0, 32'h0};
    endtask

    task automatic test_arith();
        logic [3:0]  ops [10];
        logic [31:0] as [10], bs [10];
        logic [31:0] mk, mn, a, b, hi, lo;
        logic [3:0]  o;
        logic        dz, ex;
        int          cyc, bn;
        mk  = m32();
        mn  = 32'h1 << (w - 1);
        ops = '{OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        as  = '{32'h12345678 & mk, 32'h9ABCDEF0 & mk, mk, mk, 32'hFFFFFFF9 & mk, 32'd100, mn, 32'd5,
                $urandom & mk, mn};
        bs  = '{32'h0, 32'h0, 32'h2, 32'h2, 32'h2, 32'd7, mk, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 26; i++) begin
            if (i < 10) begin
                o = ops[i]; a = as[i]; b = bs[i];
            end else begin
                o = 4'($urandom_range(0, 5));
                a = $urandom & mk;
                b = $urandom & mk;
                if ($urandom_range(0, 3) == 0) b = b & 32'h7;
            end
            issue(o, a, b);
            model(o, a, b);
            observe(cyc, bn, dz, hi, lo, ex);
            checks++;
            if ({hi, lo} !== {m_hi[s], m_lo[s]}) begin
                errors++;
                $display("FAIL hilo w%0d op%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                         w, o, a, b, hi, lo, m_hi[s], m_lo[s]);
            end
            checks++;
            if (cyc !== exp_cyc(o, b) || bn !== exp_busy(o, b)) begin
                errors++;
                $display("FAIL timing w%0d op%0d b=%h: done at cycle %0d busy %0d cycles, expected %0d and %0d",
                         w, o, b, cyc, bn, exp_cyc(o, b), exp_busy(o, b));
            end
            checks++;
            if (dz !== m_dz || ex !== 1'b0) begin
                errors++;
                $display("FAIL flags w%0d op%0d b=%h: div_zero=%b stray=%b expected div_zero=%b stray=0",
                         w, o, b, dz, ex, m_dz);
            end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] a, b, hi, lo;
        logic        dz, ex;
        int          cyc, bn;
        issue(OP_DIV, $urandom & m32(), ($urandom & m32()) | 32'h1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1; op = OP_MTHI; src1 = ~m_hi[s];
            end
            if (i == 4) start = 1'b0;
            if (i == 10) cancel = 1'b1;
        end
        @(posedge clk);
        #1;
        cancel = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_hi !== m_hi[s] || o_lo !== m_lo[s]) begin
            errors++;
            $display("FAIL cancel_div w%0d: busy=%b done=%b hi=%h lo=%h expected busy=0 done=0 hi=%h lo=%h",
                     w, o_busy, o_done, o_hi, o_lo, m_hi[s], m_lo[s]);
        end
        a = $urandom & m32();
        b = $urandom & m32();
        issue(OP_MULT, a, b);
        model(OP_MULT, a, b);
        observe(cyc, bn, dz, hi, lo, ex);
        checks++;
        if ({hi, lo} !== {m_hi[s], m_lo[s]} || cyc !== lat + 1) begin
            errors++;
            $display("FAIL mult_after_cancel w%0d: hi=%h lo=%h at cycle %0d expected hi=%h lo=%h at cycle %0d",
                     w, hi, lo, cyc, m_hi[s], m_lo[s], lat + 1);
        end
    endtask

    task automatic test_cancel_edge();
        logic [3:0] o;
        int         at, nd;
        for (int j = 0; j < 2; j++) begin
            o  = (j == 0) ? OP_MULTU : OP_DIVU;
            at = (j == 0) ? lat : w + 1;
            issue(o, ($urandom & m32()) | 32'h3, ($urandom & m32()) | 32'h1);
            for (int i = 1; i <= at; i++) begin
                @(negedge clk);
                if (i == at) cancel = 1'b1;
            end
            @(posedge clk);
            #1;
            cancel = 1'b0;
            nd = 0;
            repeat (8) begin
                @(negedge clk);
                if (o_done) nd++;
            end
            checks++;
            if (nd !== 0 || o_busy !== 1'b0 || o_hi !== m_hi[s] || o_lo !== m_lo[s]) begin
                errors++;
                $display("FAIL cancel_write_edge w%0d op%0d: done pulses %0d busy=%b hi=%h lo=%h expected 0 0 hi=%h lo=%h",
                         w, o, nd, o_busy, o_hi, o_lo, m_hi[s], m_lo[s]);
            end
        end
    endtask

    task automatic test_cancel_start();
        int nd;
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_MTLO; src1 = ~m_lo[s];
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done || o_busy) nd++;
        end
        checks++;
        if (nd !== 0 || o_lo !== m_lo[s]) begin
            errors++;
            $display("FAIL cancel_with_start w%0d: done/busy cycles %0d lo=%h expected 0 lo=%h",
                     w, nd, o_lo, m_lo[s]);
        end
    endtask

    task automatic test_reset_mid();
        issue(OP_DIV, $urandom & m32(), ($urandom & m32()) | 32'h1);
        repeat (5) @(negedge clk);
        rst = 1'b1; cancel = 1'b1; start = 1'b1; op = OP_MTHI; src1 = $urandom;
        @(posedge clk);
        #1;
        rst = 1'b0; cancel = 1'b0; start = 1'b0;
        m_hi = '{32'h0, 32'h0};
        m_lo = '{32'h0, 32'h0};
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_dz !== 1'b0 || o_hi !== 32'h0 || o_lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_div w%0d: busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
                     w, o_busy, o_done, o_dz, o_hi, o_lo);
        end
    endtask

    initial begin
        test_reset();
        for (int c = 0; c < 2; c++) begin
            set_cfg(c);
            test_arith();
            test_cancel();
            test_cancel_edge();
            test_cancel_start();
            test_reset_mid();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width (even, >= 8).
REQ-002 Parameter MUL_LAT, default 2, multiply latency in cycles (>= 1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request; accepted on an edge where start=1, busy=0, cancel=0.
REQ-006 op  in  4  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes from shared defines).
REQ-007 src1  in  WIDTH  rs operand (dividend / multiplicand / move source).
REQ-008 src2  in  WIDTH  rt operand (divisor / multiplier).
REQ-009 cancel  in  1  flush from exception/branch; aborts any in-flight op.
REQ-010 busy  out  1  high while a MULT/DIV is in flight; pipeline stalls MFHI/MFLO/new ops on it.
REQ-011 done  out  1  one-cycle pulse when the accepted op's HI/LO write is visible.
REQ-012 div_zero  out  1  valid with done; 1 if the completed DIV/DIVU had src2=0.
REQ-013 hi_o, lo_o  out  WIDTH each  current architectural HI and LO.

Function
REQ-014 FSM states IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-015 Operands and op latched at the accepting edge E0; later input changes have no effect.
REQ-016 start while busy=1 is ignored (not queued).
REQ-017 MTHI/MTLO: HI (resp. LO) <= src1 at E0; state stays IDLE; done=1 in cycle after E0.
REQ-018 MULT/MULTU: {HI,LO} <= signed/unsigned 2*WIDTH product at edge E0+MUL_LAT; done=1 and busy=0 in the following cycle.
REQ-019 DIV/DIVU: radix-2 restoring, one quotient bit per cycle; {HI,LO} written at edge E0+WIDTH+1 (WIDTH iterations + one sign-fix cycle); done=1, busy=0 in the following cycle.
REQ-020 DIV signed: quotient truncates toward zero -> LO; remainder takes dividend's sign -> HI.
REQ-021 DIV of most-negative by -1: LO = most-negative value, HI = 0; no flag.
REQ-022 Divisor zero: no iteration; HI/LO unchanged; done=1, div_zero=1 in cycle after E0; busy stays 0.
REQ-023 cancel=1: in-flight op aborted, HI/LO unchanged, no done pulse, busy=0 next cycle.
REQ-024 cancel and start in same cycle: cancel wins, start ignored.
REQ-025 cancel in the cycle of the HI/LO-writing edge: write suppressed.
REQ-026 done and div_zero are 0 in all cycles except the completion cycle.
REQ-027 hi_o/lo_o are registered outputs; no combinational path from src1/src2 to any output.

Reset
REQ-028 rst=1 at an edge: state IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0; any in-flight op discarded.
REQ-029 rst has priority over cancel and start.

Structure
REQ-030 Op codes (MULT, MULTU, DIV, DIVU, MTHI, MTLO) live in the shared defines header, reused by decode and ALU.
REQ-031 Divider datapath is a sub-module div_iter (WIDTH-parametrised: load, step, sign-fix, quotient/remainder out); multiplier is a MUL_LAT-stage pipeline in muldiv_hilo.
REQ-032 Estimated RTL 150-300 lines total.

Verification
REQ-033 rst, then MTHI 0x12345678, MTLO 0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0 after E0, done one cycle each, busy never high.
REQ-034 MULT 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE; done exactly MUL_LAT+1 cycles after start.
REQ-035 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; busy high 33 cycles, done at cycle 34 (WIDTH=32).
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5 / 0 -> div_zero=1, HI/LO unchanged.
REQ-037 DIV started, cancel at cycle 10 -> no done, HI/LO unchanged, busy=0 next cycle; new MULT accepted immediately after; start during busy ignored.
REQ-038 rst asserted mid-DIV -> HI=LO=0, busy=0 next cycle; repeat all above with WIDTH=16, MUL_LAT=1.
